// File: rtl/teclado_scan_ctrl_if.sv
// Key queue port of the keypad scan controller: FIFO head with valid/ack pop,
// accept pulse and sticky overflow flag.
interface teclado_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       done;
  logic       overflow;
  logic       clr_ovf;

  modport master (
    output key_code, key_valid, done, overflow,
    input  key_ack, clr_ovf
  );

  modport slave (
    input  key_code, key_valid, done, overflow,
    output key_ack, clr_ovf
  );
endinterface

// File: rtl/teclado_scan_ctrl.sv
// 4x4 keypad scanner: one-hot row drive, debounced single-key detection,
// 4-bit key encoding and a small FIFO read through a valid/ack handshake.
module teclado_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       entrada1,
  input  logic                       entrada2,
  input  logic                       entrada3,
  input  logic                       entrada4,
  output logic [3:0]                 fila,
  teclado_scan_ctrl_if.master        kbus
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PUSH,
    ST_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      fila_q, fila_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [3:0]      mem_d [FIFO_DEPTH];
  logic            ovf_q, ovf_d;

  logic [3:0]      cols;
  logic [3:0]      fila_rot;
  logic            tick;
  logic            single;
  logic            col_hit;
  logic            push_req;
  logic            done_c;
  logic            full;
  logic            pop;
  logic            push;

  function automatic logic [1:0] enc2(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign cols     = {entrada4, entrada3, entrada2, entrada1};
  assign fila_rot = {fila_q[2:0], fila_q[3]};
  assign tick     = (div_q == DIV_LAST);
  assign single   = (cols != 4'b0000) && ((cols & (cols - 4'b0001)) == 4'b0000);
  assign col_hit  = single && (cols == (4'b0001 << col_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SCAN;
      div_q   <= '0;
      cnt_q   <= '0;
      fila_q  <= 4'b0001;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      fila_q  <= fila_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Row drive and latched key live alongside the state so they move on the same tick.
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    cnt_d   = cnt_q;
    fila_d  = fila_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (single) begin
            row_d   = enc2(fila_q);
            col_d   = enc2(cols);
            cnt_d   = CNT_ONE;
            state_d = (CNT_DONE == CNT_ONE) ? ST_PUSH : ST_DEBOUNCE;
          end else begin
            fila_d = fila_rot;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (col_hit) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == CNT_DONE) state_d = ST_PUSH;
          end else begin
            cnt_d   = '0;
            fila_d  = fila_rot;
            state_d = ST_SCAN;
          end
        end
      end
      ST_PUSH: begin
        cnt_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (tick) begin
          if (cols == 4'b0000) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == CNT_DONE) begin
              cnt_d   = '0;
              fila_d  = fila_rot;
              state_d = ST_SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    done_c   = (state_q == ST_PUSH);
    push_req = (state_q == ST_PUSH);
  end

  // A pop in the push cycle frees a slot, so a full queue still accepts the key.
  always_comb begin
    full     = (count_q == FIFO_FULL);
    pop      = kbus.key_ack && (count_q != '0);
    push     = push_req && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {row_q, col_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + NW'(1);
    else if (pop && !push) count_d = count_q - NW'(1);
    ovf_d = ovf_q;
    if (push_req && full && !pop) ovf_d = 1'b1;
    else if (kbus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fila           = fila_q;
  assign kbus.key_code  = mem_q[rd_ptr_q];
  assign kbus.key_valid = (count_q != '0);
  assign kbus.done      = done_c;
  assign kbus.overflow  = ovf_q;

endmodule
